// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter with round-robin grant and
// read-modify-write sequencing for partial stores. Macro DMEM_ARB_CPU_PRIO_EN.
// Ports: clk, rst_n; port C (c_req/c_we/c_be/c_addr/c_wd -> c_gnt/c_rvalid/c_rd),
// port D (same, d_*), memory side (m_we/m_addr/m_wd <- m_rd), busy.
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [3:0]  c_be,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wd,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rd,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wd,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rd,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  input  logic [31:0] m_rd,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    IDLE,
    WB
  } state_e;

  state_e      state_q, state_d;
  logic        c_rvalid_q, c_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] c_rd_q, c_rd_d;
  logic [31:0] d_rd_q, d_rd_d;
  logic [31:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] m_addr_q;

  logic        pick_c;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wd;
  logic [31:0] s_waddr;
  logic [31:0] mask;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{c_addr[1:0], d_addr[1:0]};

`ifdef DMEM_ARB_CPU_PRIO_EN
  assign pick_c = c_req;
`else
  // last_q = 1 when D was granted most recently
  logic last_q, last_d;

  assign last_d = (c_gnt | d_gnt) ? d_gnt : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign pick_c = c_req & (~d_req | last_q);
`endif

  assign s_we   = pick_c ? c_we   : d_we;
  assign s_be   = pick_c ? c_be   : d_be;
  assign s_addr = pick_c ? c_addr : d_addr;
  assign s_wd   = pick_c ? c_wd   : d_wd;

  assign s_waddr = {s_addr[31:AW+2], s_addr[AW+1:2], 2'b00};

  assign mask = {{8{s_be[3]}}, {8{s_be[2]}},
                 {8{s_be[1]}}, {8{s_be[0]}}};

  always_comb begin
    state_d    = state_q;
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
    m_we       = 1'b0;
    m_wd       = 32'h0;
    m_addr     = m_addr_q;
    c_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    c_rd_d     = c_rd_q;
    d_rd_d     = d_rd_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (c_req | d_req) begin
          c_gnt  = pick_c;
          d_gnt  = ~pick_c;
          m_addr = s_waddr;
          if (!s_we) begin
            if (pick_c) begin
              c_rd_d     = m_rd;
              c_rvalid_d = 1'b1;
            end else begin
              d_rd_d     = m_rd;
              d_rvalid_d = 1'b1;
            end
          end else if (s_be == 4'hF) begin
            m_we = 1'b1;
            m_wd = s_wd;
          end else if (s_be != 4'h0) begin
            // partial store: merge now, write whole word next cycle
            wb_data_d = (m_rd & ~mask) | (s_wd & mask);
            wb_addr_d = s_waddr;
            state_d   = WB;
          end
        end
      end
      WB: begin
        m_we    = 1'b1;
        m_addr  = wb_addr_q;
        m_wd    = wb_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rd_q     <= 32'h0;
      d_rd_q     <= 32'h0;
      wb_addr_q  <= 32'h0;
      wb_data_q  <= 32'h0;
      m_addr_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rd_q     <= c_rd_d;
      d_rd_q     <= d_rd_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      m_addr_q   <= m_addr;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rd     = c_rd_q;
  assign d_rd     = d_rd_q;
  assign busy     = (state_q == WB);

endmodule
